// File: rtl/echo_sample_sequencer_if.sv
// Control, sample and status bundle between the echo-canceller front end and the sample sequencer.
interface echo_sample_sequencer_if;
  logic        enable;
  logic [12:0] set_sampling_period;
  logic [3:0]  set_lag;
  logic [15:0] adc_sig16b;
  logic        adc_valid;
  logic [15:0] rx_sig16b;
  logic        rx_valid;
  logic        clear_flags;
  logic [12:0] sampling_cycle_counter;
  logic        frame_start;
  logic [15:0] sig16b;
  logic [15:0] sig16b_lag;
  logic [12:0] frame_count;
  logic        overrun;
  logic        underrun;

  modport master (
    output enable, set_sampling_period, set_lag, adc_sig16b, adc_valid,
           rx_sig16b, rx_valid, clear_flags,
    input  sampling_cycle_counter, frame_start, sig16b, sig16b_lag,
           frame_count, overrun, underrun
  );

  modport slave (
    input  enable, set_sampling_period, set_lag, adc_sig16b, adc_valid,
           rx_sig16b, rx_valid, clear_flags,
    output sampling_cycle_counter, frame_start, sig16b, sig16b_lag,
           frame_count, overrun, underrun
  );
endinterface

// File: rtl/echo_sample_sequencer.sv
// Frames asynchronous send/receive sample strobes into fixed-length periods and presents
// one lag-aligned send sample plus one received sample per frame to the downstream canceller.
module echo_sample_sequencer #(
  parameter int HIST_DEPTH = 16
) (
  input  logic                    clk_operation,
  input  logic                    rst,
  echo_sample_sequencer_if.slave  bus
);
  localparam int IDX_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  logic [12:0]      period_r;
  logic [12:0]      eff_period_s;
  logic [12:0]      term_cnt_s;
  logic [12:0]      cnt_r;
  logic [12:0]      frame_count_r;
  logic [3:0]       lag_r;
  logic [IDX_W-1:0] lag_idx_s;
  logic             frame_start_r;
  logic             wrap_s;
  logic [15:0]      pend_tx_r;
  logic [15:0]      pend_rx_r;
  logic             tx_got_r;
  logic             rx_got_r;
  logic [15:0]      new_tx_s;
  logic [15:0]      new_rx_s;
  logic [15:0]      aligned_s;
  logic [15:0]      sig_r;
  logic [15:0]      sig_lag_r;
  logic [15:0]      hist_r [HIST_DEPTH];
  logic             overrun_r;
  logic             underrun_r;
  logic             ovr_evt_s;
  logic             und_evt_s;

  // Frame timing, wrap-time sample selection and flag events.
  always_comb begin
    eff_period_s = period_r;
    term_cnt_s   = 13'd0;
    wrap_s       = 1'b0;
    new_tx_s     = pend_tx_r;
    new_rx_s     = pend_rx_r;
    aligned_s    = 16'd0;
    lag_idx_s    = IDX_W'(lag_r - 4'd1);
    ovr_evt_s    = 1'b0;
    und_evt_s    = 1'b0;

    // A period below 2 would make frame_start a constant; clamp it.
    if (period_r < 13'd2) begin
      eff_period_s = 13'd2;
    end else begin
      eff_period_s = period_r;
    end
    term_cnt_s = eff_period_s - 13'd1;

    if (bus.enable && (cnt_r == term_cnt_s)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end

    if (bus.adc_valid) begin
      new_tx_s = bus.adc_sig16b;
    end else begin
      new_tx_s = pend_tx_r;
    end

    if (bus.rx_valid) begin
      new_rx_s = bus.rx_sig16b;
    end else begin
      new_rx_s = pend_rx_r;
    end

    if (lag_r == 4'd0) begin
      aligned_s = new_tx_s;
    end else begin
      aligned_s = hist_r[lag_idx_s];
    end

    if (bus.enable) begin
      ovr_evt_s = (bus.adc_valid & tx_got_r) | (bus.rx_valid & rx_got_r);
    end else begin
      ovr_evt_s = 1'b0;
    end

    if (wrap_s) begin
      und_evt_s = (~tx_got_r & ~bus.adc_valid) | (~rx_got_r & ~bus.rx_valid);
    end else begin
      und_evt_s = 1'b0;
    end
  end

  // Counter, pending samples, history line and frame outputs.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      cnt_r         <= 13'd0;
      frame_count_r <= 13'd0;
      frame_start_r <= 1'b0;
      period_r      <= bus.set_sampling_period;
      lag_r         <= bus.set_lag;
      pend_tx_r     <= 16'd0;
      pend_rx_r     <= 16'd0;
      tx_got_r      <= 1'b0;
      rx_got_r      <= 1'b0;
      sig_r         <= 16'd0;
      sig_lag_r     <= 16'd0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_r[k] <= 16'd0;
      end
    end else if (bus.enable) begin
      frame_start_r <= wrap_s;
      if (wrap_s) begin
        cnt_r         <= 13'd0;
        frame_count_r <= frame_count_r + 13'd1;
        period_r      <= bus.set_sampling_period;
        lag_r         <= bus.set_lag;
        sig_r         <= aligned_s;
        sig_lag_r     <= new_rx_s;
        // Keeping the last sample lets an empty frame repeat it.
        pend_tx_r     <= new_tx_s;
        pend_rx_r     <= new_rx_s;
        tx_got_r      <= 1'b0;
        rx_got_r      <= 1'b0;
        hist_r[0]     <= new_tx_s;
        for (int k = 1; k < HIST_DEPTH; k++) begin
          hist_r[k] <= hist_r[k-1];
        end
      end else begin
        cnt_r <= cnt_r + 13'd1;
        if (bus.adc_valid) begin
          pend_tx_r <= bus.adc_sig16b;
          tx_got_r  <= 1'b1;
        end else begin
          pend_tx_r <= pend_tx_r;
          tx_got_r  <= tx_got_r;
        end
        if (bus.rx_valid) begin
          pend_rx_r <= bus.rx_sig16b;
          rx_got_r  <= 1'b1;
        end else begin
          pend_rx_r <= pend_rx_r;
          rx_got_r  <= rx_got_r;
        end
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky status flags; a same-cycle set beats clear_flags.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (ovr_evt_s) begin
        overrun_r <= 1'b1;
      end else if (bus.clear_flags) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (und_evt_s) begin
        underrun_r <= 1'b1;
      end else if (bus.clear_flags) begin
        underrun_r <= 1'b0;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

  assign bus.sampling_cycle_counter = cnt_r;
  assign bus.frame_start            = frame_start_r;
  assign bus.sig16b                 = sig_r;
  assign bus.sig16b_lag             = sig_lag_r;
  assign bus.frame_count            = frame_count_r;
  assign bus.overrun                = overrun_r;
  assign bus.underrun               = underrun_r;
endmodule

// File: tb/tb_echo_sample_sequencer.sv
// Directed plus randomized bench for echo_sample_sequencer against a frame-level reference model.
module tb_echo_sample_sequencer;
  logic clk;
  logic rst;
  echo_sample_sequencer_if bus();

  echo_sample_sequencer #(.HIST_DEPTH(16)) dut (
    .clk_operation(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: counter position, strobes seen this frame, last samples, sent-sample history.
  int          m_cnt, m_P, m_lag, m_fc, n_tx, n_rx;
  logic        m_fs, m_ovr, m_und;
  logic [15:0] m_sig, m_siglag, m_last_tx, m_last_rx;
  logic [15:0] m_hist[$];

  // Stimulus configuration for run_frame (positions are counter values, -1 = never).
  int          tx_pos1 = -1, tx_pos2 = -1, rx_pos = -1, per_at = -1, frame_len = 0;
  logic [15:0] tx_v1 = 16'd0, tx_v2 = 16'd0, rx_v = 16'd0;
  logic [12:0] per_val = 13'd0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  p;
    bit  ovr, und;
    ovr = 1'b0;
    und = 1'b0;
    if (rst) begin
      m_cnt = 0; m_fs = 1'b0; m_sig = 16'd0; m_siglag = 16'd0; m_fc = 0;
      m_ovr = 1'b0; m_und = 1'b0; m_last_tx = 16'd0; m_last_rx = 16'd0;
      n_tx = 0; n_rx = 0;
      m_P = int'(bus.set_sampling_period);
      m_lag = int'(bus.set_lag);
      m_hist.delete();
      for (int i = 0; i < 16; i++) m_hist.push_back(16'd0);
      return;
    end
    if (bus.enable) begin
      p = (m_P < 2) ? 2 : m_P;
      if (bus.adc_valid) begin
        n_tx++;
        m_last_tx = bus.adc_sig16b;
        if (n_tx > 1) ovr = 1'b1;
      end
      if (bus.rx_valid) begin
        n_rx++;
        m_last_rx = bus.rx_sig16b;
        if (n_rx > 1) ovr = 1'b1;
      end
      if (m_cnt == p - 1) begin
        if (n_tx == 0 || n_rx == 0) und = 1'b1;
        m_sig = (m_lag == 0) ? m_last_tx : m_hist[m_lag - 1];
        m_hist.push_front(m_last_tx);
        void'(m_hist.pop_back());
        m_siglag = m_last_rx;
        m_fc = (m_fc + 1) % 8192;
        n_tx = 0; n_rx = 0;
        m_P = int'(bus.set_sampling_period);
        m_lag = int'(bus.set_lag);
        m_cnt = 0;
        m_fs = 1'b1;
      end else begin
        m_cnt++;
        m_fs = 1'b0;
      end
    end
    m_ovr = ovr ? 1'b1 : (bus.clear_flags ? 1'b0 : m_ovr);
    m_und = und ? 1'b1 : (bus.clear_flags ? 1'b0 : m_und);
  endtask

  task automatic compare_all();
    chk("counter",     16'(bus.sampling_cycle_counter), 16'(m_cnt));
    chk("frame_start", 16'(bus.frame_start),            16'(m_fs));
    chk("sig16b",      bus.sig16b,                      m_sig);
    chk("sig16b_lag",  bus.sig16b_lag,                  m_siglag);
    chk("frame_count", 16'(bus.frame_count),            16'(m_fc));
    chk("overrun",     16'(bus.overrun),                16'(m_ovr));
    chk("underrun",    16'(bus.underrun),               16'(m_und));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run_frame();
    frame_len = 0;
    for (int i = 0; i < 10000; i++) begin
      bus.adc_valid  = (m_cnt == tx_pos1) || (m_cnt == tx_pos2);
      bus.adc_sig16b = (m_cnt == tx_pos2) ? tx_v2 : tx_v1;
      bus.rx_valid   = (m_cnt == rx_pos);
      bus.rx_sig16b  = rx_v;
      if (m_cnt == per_at) bus.set_sampling_period = per_val;
      step();
      frame_len++;
      if (m_fs) break;
    end
    bus.adc_valid = 1'b0;
    bus.rx_valid  = 1'b0;
    chk("frame_done", 16'(bus.frame_start), 16'd1);
  endtask

  task automatic do_reset(input logic [12:0] per, input logic [3:0] lag);
    rst = 1'b1;
    bus.set_sampling_period = per;
    bus.set_lag = lag;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.set_sampling_period = 13'd100;
    bus.set_lag = 4'd0;
    bus.adc_sig16b = 16'd0;
    bus.adc_valid = 1'b0;
    bus.rx_sig16b = 16'd0;
    bus.rx_valid = 1'b0;
    bus.clear_flags = 1'b0;
    // Strobes during reset must be ignored.
    bus.adc_valid = 1'b1; bus.adc_sig16b = 16'hBEEF;
    step();
    bus.adc_valid = 1'b0;
    do_reset(13'd100, 4'd0);
    chk("rst_counter", 16'(bus.sampling_cycle_counter), 16'd0);
    chk("rst_sig16b",  bus.sig16b, 16'd0);
    chk("rst_fs",      16'(bus.frame_start), 16'd0);

    // Nominal frames: one strobe per path, lag 0.
    tx_pos1 = 10; tx_v1 = 16'h1234; rx_pos = 20; rx_v = 16'h0F0F;
    for (int f = 0; f < 3; f++) begin
      run_frame();
      chk("nom_len",   16'(frame_len), 16'd100);
      chk("nom_sig",   bus.sig16b, 16'h1234);
      chk("nom_lag",   bus.sig16b_lag, 16'h0F0F);
      chk("nom_flags", {14'd0, bus.overrun, bus.underrun}, 16'd0);
    end

    // Lag 3 alignment.
    do_reset(13'd20, 4'd3);
    tx_pos1 = 5; rx_pos = 7;
    for (int k = 1; k <= 5; k++) begin
      tx_v1 = 16'(k); rx_v = 16'(k);
      run_frame();
      chk("lag3_sig", bus.sig16b, (k <= 3) ? 16'd0 : 16'(k - 3));
    end

    // Overrun: two send strobes, newest wins; then clear.
    do_reset(13'd20, 4'd0);
    tx_pos1 = 3; tx_v1 = 16'h0001; tx_pos2 = 8; tx_v2 = 16'h0002; rx_pos = 5; rx_v = 16'h0055;
    run_frame();
    chk("ovr_flag", 16'(bus.overrun), 16'd1);
    chk("ovr_sig",  bus.sig16b, 16'h0002);
    bus.clear_flags = 1'b1;
    step();
    bus.clear_flags = 1'b0;
    chk("ovr_clear", 16'(bus.overrun), 16'd0);

    // Underrun: received sample repeats.
    tx_pos2 = -1; tx_pos1 = 4; tx_v1 = 16'h0005; rx_pos = 9; rx_v = 16'h00AA;
    run_frame();
    chk("und_pre", 16'(bus.underrun), 16'd0);
    rx_pos = -1; rx_v = 16'h0000;
    run_frame();
    chk("und_flag", 16'(bus.underrun), 16'd1);
    chk("und_lag",  bus.sig16b_lag, 16'h00AA);

    // Period changes take effect on the next frame; period 1 clamps to 2.
    rx_pos = 6;
    bus.set_sampling_period = 13'd100;
    run_frame();
    per_at = 30; per_val = 13'd50;
    run_frame();
    chk("per_100", 16'(frame_len), 16'd100);
    per_at = 10; per_val = 13'd1;
    run_frame();
    chk("per_50", 16'(frame_len), 16'd50);
    per_at = -1; tx_pos1 = 0; rx_pos = 1;
    run_frame();
    chk("per_1a", 16'(frame_len), 16'd2);
    run_frame();
    chk("per_1b", 16'(frame_len), 16'd2);

    // Enable low freezes everything; reset mid-frame clears all.
    bus.set_sampling_period = 13'd100;
    run_frame();
    tx_pos1 = -1; rx_pos = -1;
    for (int i = 0; i < 200 && m_cnt != 40; i++) step();
    chk("en_at40", 16'(bus.sampling_cycle_counter), 16'd40);
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.adc_valid = 1'b1; bus.adc_sig16b = 16'($urandom);
      bus.rx_valid  = 1'b1; bus.rx_sig16b  = 16'($urandom);
      step();
    end
    bus.adc_valid = 1'b0; bus.rx_valid = 1'b0;
    chk("en_hold", 16'(bus.sampling_cycle_counter), 16'd40);
    bus.enable = 1'b1;
    for (int i = 0; i < 200 && m_cnt != 60; i++) step();
    chk("en_at60", 16'(bus.sampling_cycle_counter), 16'd60);
    do_reset(13'd100, 4'd0);
    chk("rst60_cnt", 16'(bus.sampling_cycle_counter), 16'd0);
    chk("rst60_out", bus.sig16b | bus.sig16b_lag | 16'(bus.frame_count), 16'd0);

    // Randomized traffic, configuration changes, enable drops, clears and resets.
    do_reset(13'd12, 4'd2);
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.clear_flags = ($urandom_range(0, 49) == 0);
      bus.adc_valid = ($urandom_range(0, 99) < 9);
      bus.adc_sig16b = 16'($urandom);
      bus.rx_valid = ($urandom_range(0, 99) < 9);
      bus.rx_sig16b = 16'($urandom);
      if ($urandom_range(0, 29) == 0) bus.set_sampling_period = 13'($urandom_range(0, 30));
      if ($urandom_range(0, 29) == 0) bus.set_lag = 4'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
